// File: rtl/input_debouncer.sv
// Debounces a raw asynchronous level into a clean synchronous x_out with rise/fall pulses.
// Optional rejected-glitch counter is built when DEBOUNCE_GLITCH_CNT_EN is defined.
module input_debouncer #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 3,
    parameter int GLITCH_W      = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                raw_in,
    output logic                x_out,
    output logic                rise_p,
    output logic                fall_p,
`ifdef DEBOUNCE_GLITCH_CNT_EN
    output logic [GLITCH_W-1:0] glitch_cnt,
`endif
    output logic                busy
);

    if (STABLE_CYCLES < 2 || STABLE_CYCLES > (2**CNT_W) - 1 || GLITCH_W < 1) begin : g_bad_params
        $error("input_debouncer: illegal STABLE_CYCLES/CNT_W/GLITCH_W combination");
    end

    typedef enum logic {STABLE = 1'b0, PENDING = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s1_q, s1_d, s2_q, s2_d;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             x_q, x_d, rise_q, rise_d, fall_q, fall_d, busy_q, busy_d;

    always_comb begin
        s1_d    = raw_in;
        s2_d    = s1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        case (state_q)
            STABLE: begin
                if (s2_q != x_q) begin
                    state_d = PENDING;
                    cnt_d   = CNT_W'(1);
                end else begin
                    cnt_d   = '0;
                end
            end
            PENDING: begin
                // A single matching sample throws away all accumulated credit.
                if (s2_q == x_q) begin
                    state_d = STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    x_d     = ~x_q;
                    rise_d  = ~x_q;
                    fall_d  = x_q;
                    state_d = STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STABLE;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d == PENDING);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q    <= 1'b0;
            s2_q    <= 1'b0;
            state_q <= STABLE;
            cnt_q   <= '0;
            x_q     <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            busy_q  <= busy_d;
        end
    end

    assign x_out  = x_q;
    assign rise_p = rise_q;
    assign fall_p = fall_q;
    assign busy   = busy_q;

`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [GLITCH_W-1:0] glitch_q, glitch_d;
    logic                glitch_hit;

    // Saturating count of PENDING exits caused by a matching sample.
    always_comb begin
        glitch_hit = (state_q == PENDING) && (s2_q == x_q);
        glitch_d   = glitch_q;
        if (glitch_hit && glitch_q != {GLITCH_W{1'b1}}) begin
            glitch_d = glitch_q + GLITCH_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            glitch_q <= '0;
        end else begin
            glitch_q <= glitch_d;
        end
    end

    assign glitch_cnt = glitch_q;
`endif

endmodule

// File: tb/tb_input_debouncer.sv
// Scoreboard bench for input_debouncer: a run-length reference model predicts every
// cycle's outputs, a negedge monitor pops and compares them.
module tb_input_debouncer;

    localparam int SC = 4;
    localparam int CW = 3;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    localparam int GW = 2;
`else
    localparam int GW = 8;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic raw_in = 1'b0;
    logic x_out, rise_p, fall_p, busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
    logic [GW-1:0] glitch_cnt;
`endif

    always #5 clk = ~clk;

    input_debouncer #(.STABLE_CYCLES(SC), .CNT_W(CW), .GLITCH_W(GW)) dut (
        .clk       (clk),
        .reset     (reset),
        .raw_in    (raw_in),
        .x_out     (x_out),
        .rise_p    (rise_p),
        .fall_p    (fall_p),
`ifdef DEBOUNCE_GLITCH_CNT_EN
        .glitch_cnt(glitch_cnt),
`endif
        .busy      (busy)
    );

    typedef struct packed {
        logic       x;
        logic       rise;
        logic       fall;
        logic       busy;
        logic [7:0] g;
    } obs_t;

    obs_t expq[$];
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;

    // Reference model: the FSM sees raw_in two edges late; a change commits once
    // SC consecutive samples disagree with the current level.
    bit dl[$];
    bit m_x;
    int m_run;
    int m_g;
    bit prev_r = 1'b1;
    bit prev_raw = 1'b0;

    task automatic m_reset();
        dl = '{1'b0, 1'b0};
        m_x = 1'b0;
        m_run = 0;
        m_g = 0;
    endtask

    task automatic step(input bit v, input bit r);
        obs_t e;
        bit   smp, m_rise, m_fall;
        @(posedge clk);
        #1;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (prev_r) begin
            m_reset();
        end else begin
            smp = dl.pop_front();
            dl.push_back(prev_raw);
            if (smp != m_x) begin
                m_run++;
                if (m_run == SC) begin
                    m_x = ~m_x;
                    m_rise = m_x;
                    m_fall = ~m_x;
                    m_run = 0;
                end
            end else begin
                if (m_run > 0 && m_g < (1 << GW) - 1) m_g++;
                m_run = 0;
            end
        end
        raw_in = v;
        reset = r;
        prev_r = r;
        prev_raw = v;
        if (r) begin
            m_reset();
            m_rise = 1'b0;
            m_fall = 1'b0;
        end
        e.x = m_x;
        e.rise = m_rise;
        e.fall = m_fall;
        e.busy = (m_run > 0);
`ifdef DEBOUNCE_GLITCH_CNT_EN
        e.g = 8'(m_g);
`else
        e.g = 8'd0;
`endif
        expq.push_back(e);
    endtask

    task automatic hold(input bit v, input int n);
        repeat (n) step(v, 1'b0);
    endtask

    initial begin : monitor
        obs_t e, a;
        forever begin
            @(negedge clk);
            cyc++;
            if (expq.size() > 0) begin
                e = expq.pop_front();
                a.x = x_out;
                a.rise = rise_p;
                a.fall = fall_p;
                a.busy = busy;
`ifdef DEBOUNCE_GLITCH_CNT_EN
                a.g = 8'(glitch_cnt);
`else
                a.g = 8'd0;
`endif
                tests++;
                if (a !== e) begin
                    fails++;
                    $display("FAIL outputs cycle %0d: got x=%b rise=%b fall=%b busy=%b g=%0d, want x=%b rise=%b fall=%b busy=%b g=%0d",
                             cyc, a.x, a.rise, a.fall, a.busy, a.g, e.x, e.rise, e.fall, e.busy, e.g);
                end
            end
        end
    end

    initial begin : stim
        int len;
        bit v;
        m_reset();
        // Reset for 3 cycles, then quiet input.
        repeat (3) step(1'b0, 1'b1);
        hold(1'b0, 10);
        // Clean rising then falling transitions.
        hold(1'b1, 10);
        hold(1'b0, 10);
        // Pulse-width boundary: SC-1 rejected, SC accepted.
        hold(1'b1, SC - 1);
        hold(1'b0, 8);
        hold(1'b1, SC);
        hold(1'b0, 12);
        // Bounce then settle high.
        hold(1'b1, 1);
        hold(1'b0, 1);
        hold(1'b1, 1);
        hold(1'b0, 1);
        hold(1'b1, 8);
        hold(1'b0, 10);
        // Reset asserted while qualifying (cnt=2), then re-qualified.
        hold(1'b1, 4);
        repeat (3) step(1'b1, 1'b1);
        hold(1'b1, 10);
        hold(1'b0, 10);
        // Five rejected glitches exercise counter saturation.
        repeat (5) begin
            hold(1'b1, 2);
            hold(1'b0, 6);
        end
        // Randomized level runs with occasional reset.
        repeat (80) begin
            v = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 7);
            hold(v, len);
            if ($urandom_range(0, 19) == 0) step(v, 1'b1);
        end
        hold(1'b0, 10);
        @(posedge clk);
        @(posedge clk);
        tests++;
        if (expq.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending entries, want 0", expq.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/input_debouncer.md
Name: input_debouncer

Overview:
- Conditions a raw, asynchronous, possibly bouncing switch/serial level into the clean, clock-synchronous `x_in` level consumed by the downstream transition-detect FSM.
- Stages:
  - 2-flop synchronizer.
  - Stability-qualification FSM with a cycle counter; the output level toggles only after the new level has been held long enough.
  - Registered rise/fall pulse outputs.

Parameters:
- STABLE_CYCLES, 4: consecutive synchronized samples of the new level required to commit a change. Legal range 2..(2^CNT_W - 1).
- CNT_W, 3: width of the stability counter.
- GLITCH_W, 8: width of the glitch counter (used only with the optional feature).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- raw_in  input  1  unsynchronized raw level.
- x_out  output  1  debounced level; drives the downstream FSM `x_in`.
- rise_p  output  1  one-cycle pulse when `x_out` goes 0->1.
- fall_p  output  1  one-cycle pulse when `x_out` goes 1->0.
- busy  output  1  high while a candidate change is being qualified.
- glitch_cnt  output  GLITCH_W  rejected-glitch count (optional feature only).

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - While `reset`=1, these are 0: s1, s2, state (STABLE), cnt, `x_out`, `rise_p`, `fall_p`, `busy`, `glitch_cnt`.
  - Release is synchronous to the next rising edge.
- Synchronizer: s1 <= raw_in; s2 <= s1. Only s2 is used by the FSM.
- FSM states: STABLE, PENDING. All outputs are registered; `busy` = (state == PENDING).
- STABLE:
  - s2 == x_out: stay; cnt = 0.
  - s2 != x_out: go to PENDING; cnt = 1.
- PENDING:
  - s2 != x_out and cnt == STABLE_CYCLES-1: commit.
    - x_out <= ~x_out.
    - rise_p <= new x_out; fall_p <= ~new x_out.
    - state <= STABLE; cnt <= 0.
  - s2 != x_out and cnt < STABLE_CYCLES-1: cnt <= cnt+1.
  - s2 == x_out: glitch.
    - state <= STABLE; cnt <= 0; x_out unchanged; no pulse.
    - glitch_cnt increments (optional feature).
- `rise_p` and `fall_p`:
  - 0 in every cycle except the one following a commit edge.
  - Never both high.
- Latency: a raw level change held for at least STABLE_CYCLES cycles appears on `x_out` at the (STABLE_CYCLES+2)th rising edge.
  - Counting starts from the first edge that samples the new level.
  - Default: 6th edge.
- Pulse-width boundary:
  - Raw pulse of exactly STABLE_CYCLES cycles: accepted.
  - Raw pulse of STABLE_CYCLES-1 cycles or fewer: rejected.
- Reset mid-PENDING:
  - Qualification is aborted; `x_out` returns to 0; no pulse is produced.
  - After release, a held raw level of 1 is re-qualified from scratch.
- Counter arithmetic: cnt is unsigned CNT_W bits and never exceeds STABLE_CYCLES-1. No wrap is possible within the legal parameter range.
- Bounce during PENDING: any single matching sample restarts qualification. There is no partial credit.

Optional Feature:
- DEBOUNCE_GLITCH_CNT_EN defined:
  - `glitch_cnt` port exists.
  - Increments by 1 on each PENDING->STABLE glitch exit.
  - Saturates at all-ones; it does not wrap.
  - Reset to 0 by `reset` only.
- Not defined: port and counter are absent. All other behaviour is identical.

Test Plan:
- Reset 3 cycles, raw_in=0, release -> x_out=0, busy=0, rise_p=fall_p=0 for 10 cycles.
- raw_in 0->1 held 10 cycles (STABLE_CYCLES=4):
  - busy=1 during edges 3-5;
  - x_out=1 at edge 6;
  - rise_p=1 for exactly one cycle;
  - then 1->0 held gives fall_p for one cycle at edge 6.
- Accept/reject boundary:
  - raw_in=1 pulse of 3 cycles -> x_out stays 0, no pulse, glitch_cnt=1 (macro on).
  - Pulse of exactly 4 cycles -> x_out=1.
- Bounce 1,0,1,0 at 1-cycle spacing, then 1 held 8 cycles:
  - x_out=1 exactly 6 edges after the final 0->1;
  - glitch_cnt reflects each PENDING abort.
- Assert reset when cnt=2 in PENDING (raw_in held 1) -> x_out=0 immediately (asynchronous), no rise_p; after release x_out=1 at edge 6.
- Macro on, GLITCH_W=2: inject 5 rejected glitches -> glitch_cnt reads 1,2,3,3,3 (saturates).
